// File: rtl/mux2_pkg.sv
// Shared definitions for the 2:1 mux feeder: select encodings, output-stage
// state encodings and default widths.
package mux2_pkg;

    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    localparam int DEF_WIDTH = 1;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Combinational two-way arbiter; a tie goes to the channel not named by
// `last`, or always to channel 1 when MUX2_FIXED_PRIORITY_EN is defined.
module rr_arb2
    import mux2_pkg::*;
(
    input  logic req1,
    input  logic req2,
    input  logic last,
    input  logic enable,
    output logic gnt1,
    output logic gnt2
);

`ifdef MUX2_FIXED_PRIORITY_EN
    logic unused_last;
    assign unused_last = last;
`endif

    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (enable) begin
            if (req1 && req2) begin
`ifdef MUX2_FIXED_PRIORITY_EN
                gnt1 = 1'b1;
`else
                if (last == SEL_IN2) begin
                    gnt1 = 1'b1;
                end else begin
                    gnt2 = 1'b1;
                end
`endif
            end else begin
                gnt1 = req1;
                gnt2 = req2;
            end
        end
    end

endmodule

// File: rtl/mux2_rr_feeder.sv
// Round-robin feeder for the 2:1 mux: arbitrates two valid/ready sources into a
// one-deep output register. Option macro: MUX2_FIXED_PRIORITY_EN.
module mux2_rr_feeder
    import mux2_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req1,
    input  logic [WIDTH-1:0] data1,
    input  logic             req2,
    input  logic [WIDTH-1:0] data2,
    output logic             grant1,
    output logic             grant2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             select,
    output logic [CNT_W-1:0] xfer_cnt
);

    state_t           state_q;
    state_t           state_d;
    logic             vld_p0;
    logic [WIDTH-1:0] data_p0;
    logic             sel_p0;
    logic             last_q;
    logic             can_load;
    logic             arb_en;
    logic             load;
    logic [CNT_W-1:0] cnt_q;

    assign vld_p0   = (state_q == ST_FULL);
    assign can_load = !vld_p0 || out_ready;
    // Gating with rst keeps grants low while reset is held, since it is asynchronous.
    assign arb_en   = can_load && !rst;

    rr_arb2 u_arb (
        .req1   (req1),
        .req2   (req2),
        .last   (last_q),
        .enable (arb_en),
        .gnt1   (grant1),
        .gnt2   (grant2)
    );

    assign load = grant1 || grant2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == ST_EMPTY) begin
            if (load) begin
                state_d = ST_FULL;
            end
        end else begin
            if (load) begin
                state_d = ST_FULL;
            end else if (out_ready) begin
                state_d = ST_EMPTY;
            end
        end
    end

    // Output register stage: word, its source and the round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_p0 <= '0;
            sel_p0  <= SEL_IN1;
            last_q  <= SEL_IN2;
        end else if (load) begin
            data_p0 <= grant2 ? data2 : data1;
            sel_p0  <= grant2 ? SEL_IN2 : SEL_IN1;
            last_q  <= grant2 ? SEL_IN2 : SEL_IN1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (vld_p0 && out_ready) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign out_valid = vld_p0;
    assign out_data  = data_p0;
    assign select    = sel_p0;
    assign xfer_cnt  = cnt_q;

endmodule

// File: doc/mux2_rr_feeder.md
# mux2_rr_feeder

Two-channel round-robin arbiter with a one-deep registered output stage that feeds the 2:1 multiplexer datapath. It accepts data from two valid/ready sources, picks a winner each cycle, captures the winning word into an output register, and drives the mux-convention `select` (0 = in1, 1 = in2) together with the captured word to the downstream consumer. It sits directly upstream of the mux stage and replaces free-running select stimulus with a handshaked, fair selection.

## Interface
- `WIDTH`, 1: data width of each channel and of `out_data`.
- `CNT_W`, 8: width of the transfer counter `xfer_cnt`.
- `clk` input 1: single clock; all state on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req1` input 1: channel 1 valid; `data1` stable while high and not granted.
- `data1` input WIDTH: channel 1 word (maps to mux `in1`).
- `req2` input 1: channel 2 valid.
- `data2` input WIDTH: channel 2 word (maps to mux `in2`).
- `grant1` output 1: channel 1 ready/accept; transfer when `req1 && grant1`.
- `grant2` output 1: channel 2 ready/accept.
- `out_valid` output 1: output register holds a word.
- `out_ready` input 1: consumer accepts when `out_valid && out_ready`.
- `out_data` output WIDTH: captured word.
- `select` output 1: source of `out_data` (0 = channel 1, 1 = channel 2).
- `xfer_cnt` output CNT_W: number of words delivered downstream.

## Operation
- Output FSM, two states: EMPTY (`out_valid`=0), FULL (`out_valid`=1).
- `can_load` = EMPTY, or FULL with `out_ready`=1 (drain and reload same cycle).
- Arbitration (combinational, only when `can_load`): one requester wins outright; both requesting, winner is the channel not in `last`. `grant1`/`grant2` one-hot or zero; never both.
- On a grant: `out_data` <= winner data, `select` <= winner index, `last` <= winner index, state -> FULL.
- FULL, `out_ready`=1, no request: state -> EMPTY; `out_data`/`select` hold last values.
- FULL, `out_ready`=0: no grants, register and `last` frozen.
- `xfer_cnt` increments by 1 on each `out_valid && out_ready`; wraps 2^CNT_W-1 -> 0.
- Reset: state EMPTY, `out_valid`=0, `out_data`=0, `select`=0, `last`=1 (channel 1 wins first tie), `xfer_cnt`=0; `grant1`/`grant2` 0 during reset.
- Reset mid-transfer discards the held word; no grant issued that cycle.

## Timing
- Grants combinational from `req*`, `out_ready`, state, `last`; no combinational path from data to any output.
- Latency: granted word visible on `out_data`/`select`/`out_valid` the cycle after the grant edge.
- Throughput: one word per cycle while `out_ready`=1 and any request present.
- Both requesting continuously with `out_ready`=1: grants alternate every cycle, 1,2,1,2...
- Requester may drop `req*` only after its grant; bench checks data stability.

## Configuration
- `MUX2_FIXED_PRIORITY_EN` defined: channel 1 always wins ties; `last` still updated but ignored by arbitration.
- Undefined (default): round-robin as above.

## Structure
- Shared package `mux2_pkg`: `SEL_IN1`=1'b0, `SEL_IN2`=1'b1, state encodings `ST_EMPTY`/`ST_FULL`, default `WIDTH`/`CNT_W`.
- One sub-module: `rr_arb2` (pure combinational two-way arbiter: `req1`,`req2`,`last`,`enable` -> `gnt1`,`gnt2`).
- Top holds output register, FSM, `last`, counter.

## Test plan
- Reset then `req1`=1,`data1`=1,`out_ready`=1 -> `grant1`=1 same cycle; next cycle `out_valid`=1,`out_data`=1,`select`=0,`xfer_cnt` 1 one cycle later.
- Both requesting, `data1`=0,`data2`=1, `out_ready`=1 for 4 cycles -> grants 1,2,1,2; `select` 0,1,0,1; `xfer_cnt`=4.
- FULL with `out_ready`=0 for 3 cycles, both requesting -> no grants, `out_data`/`select` unchanged; release -> grant resumes to channel not in `last`.
- `CNT_W`=2, 5 transfers -> `xfer_cnt` 1,2,3,0,1.
- Assert `rst` while FULL, `req2`=1 -> `out_valid`=0,`select`=0,`xfer_cnt`=0 immediately; after release first tie goes to channel 1.
- With `MUX2_FIXED_PRIORITY_EN`, both requesting 4 cycles -> `grant1` every cycle, `grant2` never.
